// File: rtl/load_store_unit_if.sv
// Core-side and data-memory-side signals of the load/store unit.
// The master modport is the LSU's view and the slave modport is the core/memory view.
interface load_store_unit_if;
  // Core side
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  // Data memory bus
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    input  req, we, funct3, addr, wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output rdata, busy, done, err, err_code,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );

  modport slave (
    output req, we, funct3, addr, wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  rdata, busy, done, err, err_code,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store into a single data-memory bus
// transaction with byte lanes, load extension, alignment checks and a read timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             req_legal;
  logic             req_aligned;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;

  // Decode of the incoming request, only consumed in IDLE.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    req_legal   = 1'b0;
    req_aligned = 1'b1;
    req_be      = 4'b0000;
    req_wdata   = bus.wdata;
    case (bus.funct3)
      F3_B, F3_BU: begin
        // Unsigned variants exist only for loads.
        req_legal = (bus.funct3 == F3_B) || !bus.we;
        req_be    = 4'b0001 << bus.addr[1:0];
        req_wdata = {4{bus.wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        req_legal   = (bus.funct3 == F3_H) || !bus.we;
        req_aligned = !bus.addr[0];
        req_be      = bus.addr[1] ? 4'b1100 : 4'b0011;
        req_wdata   = {2{bus.wdata[15:0]}};
      end
      F3_W: begin
        req_legal   = 1'b1;
        req_aligned = (bus.addr[1:0] == 2'b00);
        req_be      = 4'b1111;
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (f3)
      F3_B:    load_extend = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_extend = {24'h0, shifted[7:0]};
      F3_H:    load_extend = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_extend = {16'h0, shifted[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  assign bus.busy = ((state == S_IDLE) && bus.req) || (state == S_REQ) || (state == S_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: bus outputs sit in the async reset, so dmem_req drops the moment rst_n falls.
      state          <= S_IDLE;
      we_q           <= 1'b0;
      funct3_q       <= 3'b000;
      lane_q         <= 2'b00;
      wait_cnt       <= '0;
      bus.rdata      <= 32'h0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.err_code   <= ERR_NONE;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= 32'h0;
      bus.dmem_be    <= 4'b0000;
      bus.dmem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            funct3_q <= bus.funct3;
            lane_q   <= bus.addr[1:0];
            if (!req_legal) begin
              state        <= S_DONE;
              bus.done     <= 1'b1;
              bus.err      <= 1'b1;
              bus.err_code <= ERR_ILLEGAL;
              bus.rdata    <= 32'h0;
            end else if (!req_aligned) begin
              state        <= S_DONE;
              bus.done     <= 1'b1;
              bus.err      <= 1'b1;
              bus.err_code <= ERR_MISALIGN;
              bus.rdata    <= 32'h0;
            end else begin
              state          <= S_REQ;
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= bus.we;
              bus.dmem_addr  <= {bus.addr[31:2], 2'b00};
              bus.dmem_be    <= req_be;
              bus.dmem_wdata <= req_wdata;
            end
          end
        end

        S_REQ: begin
          if (bus.dmem_gnt) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            bus.dmem_be  <= 4'b0000;
            if (we_q) begin
              state     <= S_DONE;
              bus.done  <= 1'b1;
              bus.rdata <= 32'h0;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
          end
        end

        S_WAIT: begin
          // Read data wins over a timeout landing in the same cycle.
          if (bus.dmem_rvalid) begin
            state     <= S_DONE;
            bus.done  <= 1'b1;
            bus.rdata <= load_extend(funct3_q, lane_q, bus.dmem_rdata);
          end else if (wait_cnt == CNT_LAST) begin
            state        <= S_DONE;
            bus.done     <= 1'b1;
            bus.err      <= 1'b1;
            bus.err_code <= ERR_TIMEOUT;
            bus.rdata    <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          state        <= S_IDLE;
          bus.done     <= 1'b0;
          bus.err      <= 1'b0;
          bus.err_code <= ERR_NONE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, error paths,
// read timeout and asynchronous reset in the middle of an access.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  load_store_unit_if bus_if();

  load_store_unit #(.TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Leaves the bench 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    tick();
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.funct3 = f3; bus_if.addr = a; bus_if.wdata = wd;
    #1 check("st_busy_req", bus_if.busy, 1);
    tick();
    bus_if.req = 1'b0;
    check("st_dmem_req", bus_if.dmem_req, 1);
    check("st_dmem_we", bus_if.dmem_we, 1);
    check("st_dmem_addr", bus_if.dmem_addr, exp_addr);
    check("st_dmem_be", bus_if.dmem_be, exp_be);
    check("st_dmem_wdata", bus_if.dmem_wdata, exp_wdata);
    check("st_no_early_done", bus_if.done, 0);
    bus_if.dmem_gnt = 1'b1;
    tick();
    bus_if.dmem_gnt = 1'b0;
    check("st_done", bus_if.done, 1);
    check("st_err", bus_if.err, 0);
    check("st_rdata_zero", bus_if.rdata, 0);
    check("st_dmem_req_off", bus_if.dmem_req, 0);
    #1 check("st_busy_done", bus_if.busy, 0);
    tick();
    check("st_done_pulse", bus_if.done, 0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word,
                         input int gnt_delay, input int rv_delay,
                         input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    tick();
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.funct3 = f3; bus_if.addr = a;
    tick();
    bus_if.req = 1'b0;
    check("ld_dmem_req", bus_if.dmem_req, 1);
    check("ld_dmem_we", bus_if.dmem_we, 0);
    check("ld_dmem_addr", bus_if.dmem_addr, {a[31:2], 2'b00});
    check("ld_dmem_be", bus_if.dmem_be, exp_be);
    for (int i = 0; i < gnt_delay; i++) begin
      // Stray read data while the request is still ungranted must be ignored.
      bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = 32'hDEADBEEF;
      tick();
      check("ld_hold_req", bus_if.dmem_req, 1);
    end
    bus_if.dmem_rvalid = 1'b0;
    bus_if.dmem_gnt = 1'b1;
    tick();
    bus_if.dmem_gnt = 1'b0;
    check("ld_req_dropped", bus_if.dmem_req, 0);
    #1 check("ld_busy_wait", bus_if.busy, 1);
    for (int i = 1; i < rv_delay; i++) tick();
    bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = word;
    tick();
    bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
    check("ld_done", bus_if.done, 1);
    check("ld_rdata", bus_if.rdata, exp_rdata);
    check("ld_err", bus_if.err, 0);
    check("ld_err_code", bus_if.err_code, 0);
    tick();
    check("ld_done_pulse", bus_if.done, 0);
  endtask

  // Request is deliberately held high through DONE to show it is ignored there.
  task automatic do_err(input logic [2:0] f3, input logic [31:0] a, input logic [1:0] exp_code);
    tick();
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.funct3 = f3; bus_if.addr = a;
    #1 check("er_busy_req", bus_if.busy, 1);
    check("er_no_bus_req", bus_if.dmem_req, 0);
    tick();
    check("er_done", bus_if.done, 1);
    check("er_err", bus_if.err, 1);
    check("er_code", bus_if.err_code, exp_code);
    check("er_rdata", bus_if.rdata, 0);
    check("er_no_bus", bus_if.dmem_req, 0);
    #1 check("er_busy_done", bus_if.busy, 0);
    tick();
    bus_if.req = 1'b0;
    check("er_req_ignored_in_done", bus_if.done, 0);
    check("er_code_clear", bus_if.err_code, 0);
    check("er_no_bus_after", bus_if.dmem_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic early;
    rst_n = 1'b0;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.funct3 = 3'b000;
    bus_if.addr = 32'h0; bus_if.wdata = 32'h0;
    bus_if.dmem_gnt = 1'b0; bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
    repeat (2) tick();
    check("rst_rdata", bus_if.rdata, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_err", bus_if.err, 0);
    check("rst_err_code", bus_if.err_code, 0);
    check("rst_dmem_req", bus_if.dmem_req, 0);
    check("rst_dmem_we", bus_if.dmem_we, 0);
    check("rst_dmem_addr", bus_if.dmem_addr, 0);
    check("rst_dmem_be", bus_if.dmem_be, 0);
    check("rst_dmem_wdata", bus_if.dmem_wdata, 0);
    check("rst_busy", bus_if.busy, 0);
    rst_n = 1'b1;

    // Stores: byte at lane 3, halfword upper, full word.
    do_store(3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
    do_store(3'b001, 32'h0000_0012, 32'h1234_BEEF, 32'h0000_0010, 4'b1100, 32'hBEEF_BEEF);
    do_store(3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D);

    // Loads: LH/LHU upper half, LB earliest rvalid, LBU lane 1, LW.
    do_load(3'b001, 32'h0000_2002, 32'h80FF_1234, 0, 3, 4'b1100, 32'hFFFF_80FF);
    do_load(3'b101, 32'h0000_2002, 32'h80FF_1234, 2, 3, 4'b1100, 32'h0000_80FF);
    do_load(3'b000, 32'h0000_0003, 32'hA500_0000, 0, 1, 4'b1000, 32'hFFFF_FFA5);
    do_load(3'b100, 32'h0000_0001, 32'h1234_8678, 1, 2, 4'b0010, 32'h0000_0086);
    do_load(3'b010, 32'h0000_0044, 32'h89AB_CDEF, 0, 1, 4'b1111, 32'h89AB_CDEF);

    // Error paths: misaligned word/half, illegal funct3, illegal beats misaligned.
    do_err(3'b010, 32'h0000_0006, 2'b01);
    do_err(3'b001, 32'h0000_0001, 2'b01);
    do_err(3'b011, 32'h0000_0000, 2'b10);
    do_err(3'b111, 32'h0000_0003, 2'b10);

    // Read timeout: done lands exactly 64 cycles after entering WAIT.
    tick();
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.funct3 = 3'b010; bus_if.addr = 32'h0000_0040;
    tick();
    bus_if.req = 1'b0; bus_if.dmem_gnt = 1'b1;
    tick();
    bus_if.dmem_gnt = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      if (bus_if.done !== 1'b0) early = 1'b1;
      tick();
    end
    if (bus_if.done !== 1'b0) early = 1'b1;
    check("to_no_early_done", early, 0);
    tick();
    check("to_done", bus_if.done, 1);
    check("to_err", bus_if.err, 1);
    check("to_err_code", bus_if.err_code, 2'b11);
    check("to_rdata", bus_if.rdata, 0);
    tick();
    check("to_done_pulse", bus_if.done, 0);

    // Reset while REQ: dmem_req must fall without a clock edge; late grant ignored.
    tick();
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.funct3 = 3'b010; bus_if.addr = 32'h0000_0084;
    tick();
    bus_if.req = 1'b0;
    check("rr_dmem_req", bus_if.dmem_req, 1);
    #3 rst_n = 1'b0;
    #1 check("rr_async_dmem_req", bus_if.dmem_req, 0);
    check("rr_async_busy", bus_if.busy, 0);
    tick();
    rst_n = 1'b1;
    bus_if.dmem_gnt = 1'b1;
    tick();
    bus_if.dmem_gnt = 1'b0;
    bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = 32'h1111_1111;
    check("rr_late_gnt_req", bus_if.dmem_req, 0);
    check("rr_late_gnt_done", bus_if.done, 0);
    tick();
    bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
    check("rr_late_rv_done", bus_if.done, 0);
    check("rr_late_rv_rdata", bus_if.rdata, 0);

    // Reset while WAIT: state returns to IDLE at once; late rvalid ignored.
    tick();
    bus_if.req = 1'b1; bus_if.we = 1'b0; bus_if.funct3 = 3'b010; bus_if.addr = 32'h0000_0088;
    tick();
    bus_if.req = 1'b0; bus_if.dmem_gnt = 1'b1;
    tick();
    bus_if.dmem_gnt = 1'b0;
    tick();
    #1 check("rw_busy_wait", bus_if.busy, 1);
    #3 rst_n = 1'b0;
    #1 check("rw_async_busy", bus_if.busy, 0);
    check("rw_async_dmem_req", bus_if.dmem_req, 0);
    tick();
    rst_n = 1'b1;
    bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = 32'h5555_5555;
    tick();
    bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
    check("rw_late_rv_done", bus_if.done, 0);
    check("rw_late_rv_rdata", bus_if.rdata, 0);
    check("rw_late_rv_err", bus_if.err, 0);
    tick();
    check("rw_still_idle", bus_if.done, 0);

    // Normal operation resumes after the aborted accesses.
    do_load(3'b010, 32'h0000_0090, 32'h0BAD_F00D, 0, 2, 4'b1111, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles spent in WAIT before the access is aborted with a timeout error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  core requests a memory access this cycle; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; others illegal.
REQ-007 addr  input  32  byte address, driven from the ALU result.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 rdata  output  32  extended load result, valid while done=1.
REQ-010 busy  output  1  stall to core: PC and register write held while 1.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  qualifies done: access failed.
REQ-013 err_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 when err=0.
REQ-014 dmem_req  output  1  bus request.
REQ-015 dmem_we  output  1  bus write enable.
REQ-016 dmem_addr  output  32  word address: {addr[31:2],2'b00}.
REQ-017 dmem_be  output  4  byte enables.
REQ-018 dmem_wdata  output  32  lane-replicated store data.
REQ-019 dmem_gnt  input  1  bus accepts the request this cycle.
REQ-020 dmem_rvalid  input  1  read data valid this cycle.
REQ-021 dmem_rdata  input  32  read data word.

Function
REQ-022 States: IDLE, REQ, WAIT, DONE; state held in registers.
REQ-023 IDLE: on req=1, latch addr, we, funct3, wdata; go REQ if legal and aligned, else DONE with err set and no bus activity.
REQ-024 Alignment: halfword requires addr[0]=0, word requires addr[1:0]=00; byte always aligned; illegal funct3 takes priority over misaligned.
REQ-025 REQ: dmem_req=1 and bus outputs driven from latched values; on dmem_gnt: store -> DONE, load -> WAIT; else stay in REQ indefinitely.
REQ-026 WAIT: on dmem_rvalid capture the extended result -> DONE; dmem_rvalid in any other state is ignored (earliest accepted rvalid is the cycle after gnt).
REQ-027 WAIT counter: cleared on entry, increments per cycle; reaching TIMEOUT without rvalid -> DONE with err_code=11 and rdata=0.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; req ignored in DONE.
REQ-029 busy = (state==IDLE and req) or state==REQ or state==WAIT; busy=0 in DONE.
REQ-030 dmem_be: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
REQ-031 dmem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-032 Load extract: selected byte/half from lane addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-033 Store completion: rdata=0.
REQ-034 dmem_req, dmem_we, dmem_be are 0 outside REQ.

Reset
REQ-035 rst_n=0 forces IDLE immediately (asynchronously), including mid-access; dmem_req drops without waiting for clk.
REQ-036 Reset values: rdata=0, done=0, err=0, err_code=00, dmem_* outputs=0, counter=0; busy follows REQ-029.
REQ-037 A grant or rvalid arriving after reset release for an aborted access is ignored.

Verification
REQ-038 SB addr=0x1003 wdata=0x000000AB, gnt same cycle as REQ -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB, done two cycles after req.
REQ-039 LH addr=0x2002, rdata word 0x80FF1234, rvalid 3 cycles after gnt -> rdata=0xFFFF80FF, err=0; LHU same -> 0x000080FF.
REQ-040 LW addr=0x0006 -> done next cycle, err_code=01, dmem_req never asserted; funct3=011 -> err_code=10.
REQ-041 LW, gnt given, rvalid never arrives, TIMEOUT=64 -> done with err_code=11 exactly 64 cycles after entering WAIT.
REQ-042 rst_n low while in WAIT, then late rvalid -> state IDLE, done never pulses, dmem_req=0 asynchronously.
